// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider, with start/finish handshake.
interface seq_divider_if #(
  parameter int unsigned LEN = 32
);
  logic [LEN-1:0] dividend;
  logic [LEN-1:0] divisor;
  logic           start;
  logic [LEN-1:0] quotient;
  logic [LEN-1:0] remainder;
  logic           finish;
  logic           div_by_zero;

  modport master (
    output dividend, divisor, start,
    input  quotient, remainder, finish, div_by_zero
  );

  modport slave (
    input  dividend, divisor, start,
    output quotient, remainder, finish, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock. Results are
// held in output registers and refreshed only on completion.
module seq_divider #(
  parameter int unsigned LEN = 32
) (
  input logic          clk,
  input logic          rstn,
  seq_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(LEN + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [LEN:0]    rem_q, rem_d;
  logic [LEN-1:0]  q_q, q_d;
  logic [LEN-1:0]  dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]  quotient_q, quotient_d;
  logic [LEN-1:0]  remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  logic [LEN+1:0]  shifted;
  logic [LEN:0]    trial;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    shifted     = {rem_q, q_q[LEN-1]};
    trial       = shifted[LEN:0] - {1'b0, dvs_q};

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          q_d     = bus.dividend;
          dvs_d   = bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(LEN)) begin
          // All LEN steps are in the working registers; publish them.
          quotient_d  = q_q;
          remainder_d = rem_q[LEN-1:0];
          dbz_d       = (dvs_q == '0);
          state_d     = StDone;
        end else begin
          if (shifted >= {2'b00, dvs_q}) begin
            rem_d = trial;
            q_d   = {q_q[LEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[LEN:0];
            q_d   = {q_q[LEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.finish      = (state_q == StDone);

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic model.
module tb_seq_divider;

  localparam int unsigned LEN = 32;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  seq_divider_if #(.LEN(LEN)) bus ();

  seq_divider #(.LEN(LEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned division; a zero divisor gives all ones and the dividend back.
  task automatic ref_div(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                         output logic [LEN-1:0] q, output logic [LEN-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue one division from IDLE and wait for its finish pulse.
  task automatic run_op(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                        output logic [LEN-1:0] q, output logic [LEN-1:0] r,
                        output logic dbz, output int lat, output bit ok,
                        output logic fin_next);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    lat = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.finish) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
    @(posedge clk); #1;
    fin_next = bus.finish;
  endtask

  task automatic test_reset;
    rstn         = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #20;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.quotient !== '0) begin
      n_err++; $display("FAIL reset_q: got %h want 0", bus.quotient);
    end
    n_cmp++;
    if (bus.remainder !== '0) begin
      n_err++; $display("FAIL reset_r: got %h want 0", bus.remainder);
    end
    n_cmp++;
    if (bus.finish !== 1'b0) begin
      n_err++; $display("FAIL reset_finish: got %b want 0", bus.finish);
    end
    n_cmp++;
    if (bus.div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero);
    end
  endtask

  task automatic test_basic;
    logic [LEN-1:0] q, r;
    logic dbz, fn;
    int lat;
    bit ok;
    run_op(32'd100, 32'd7, q, r, dbz, lat, ok, fn);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL basic_timeout: no finish within 100 edges");
    end
    // finish is visible right after edge k+LEN+1, counting the accept edge as k
    n_cmp++;
    if (lat != LEN + 1) begin
      n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, LEN + 1);
    end
    n_cmp++;
    if (q !== 32'd14) begin
      n_err++; $display("FAIL basic_q: got %0d want 14", q);
    end
    n_cmp++;
    if (r !== 32'd2) begin
      n_err++; $display("FAIL basic_r: got %0d want 2", r);
    end
    n_cmp++;
    if (dbz !== 1'b0) begin
      n_err++; $display("FAIL basic_dbz: got %b want 0", dbz);
    end
    n_cmp++;
    if (fn !== 1'b0) begin
      n_err++; $display("FAIL basic_pulse: finish still %b one cycle later, want 0", fn);
    end
  endtask

  task automatic test_boundaries;
    logic [LEN-1:0] a_t [5];
    logic [LEN-1:0] b_t [5];
    logic [LEN-1:0] q, r, eq, er;
    logic dbz, fn;
    int lat;
    bit ok;
    a_t = '{32'hFFFF_FFFF, 32'd3, 32'd5, 32'd9, 32'd0};
    b_t = '{32'd1, 32'd10, 32'd0, 32'd3, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(a_t[i], b_t[i], q, r, dbz, lat, ok, fn);
      ref_div(a_t[i], b_t[i], eq, er);
      n_cmp++;
      if (!ok || lat != LEN + 1) begin
        n_err++; $display("FAIL bound%0d_latency: got %0d want %0d", i, lat, LEN + 1);
      end
      n_cmp++;
      if (q !== eq || r !== er) begin
        n_err++;
        $display("FAIL bound%0d_result: got q=%h r=%h want q=%h r=%h", i, q, r, eq, er);
      end
      n_cmp++;
      if (dbz !== (b_t[i] == 0)) begin
        n_err++; $display("FAIL bound%0d_dbz: got %b want %b", i, dbz, b_t[i] == 0);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [LEN-1:0] q, r, q_first, r_first;
    logic dbz, fn;
    int lat, fin_cnt;
    bit ok;
    run_op(32'd77, 32'd5, q, r, dbz, lat, ok, fn);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    fin_cnt   = 0;
    q_first   = '0;
    r_first   = '0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        bus.start    = 1'b1;
        bus.dividend = 32'h1234_5678;
        bus.divisor  = 32'h10;
      end
      if (i == 8) begin
        bus.start = 1'b0;
        n_cmp++;
        if (bus.quotient !== 32'd15 || bus.remainder !== 32'd2) begin
          n_err++;
          $display("FAIL hold_busy: got q=%0d r=%0d want q=15 r=2", bus.quotient,
                   bus.remainder);
        end
      end
      @(posedge clk); #1;
      if (bus.finish) begin
        fin_cnt++;
        if (fin_cnt == 1) begin
          q_first = bus.quotient;
          r_first = bus.remainder;
        end
      end
    end
    n_cmp++;
    if (fin_cnt != 1) begin
      n_err++; $display("FAIL ignore_count: got %0d finishes want 1", fin_cnt);
    end
    n_cmp++;
    if (q_first !== 32'd14 || r_first !== 32'd2) begin
      n_err++; $display("FAIL ignore_result: got q=%0d r=%0d want q=14 r=2", q_first, r_first);
    end
  endtask

  task automatic test_reset_mid;
    logic [LEN-1:0] q, r;
    logic dbz, fn;
    int lat, fin_cnt;
    bit ok;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.quotient !== '0 || bus.remainder !== '0 || bus.finish !== 1'b0 ||
        bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: got q=%h r=%h fin=%b dbz=%b want all 0", bus.quotient,
               bus.remainder, bus.finish, bus.div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn    = 1'b1;
    fin_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.finish) fin_cnt++;
    end
    n_cmp++;
    if (fin_cnt != 0) begin
      n_err++; $display("FAIL midreset_nofinish: got %0d finishes want 0", fin_cnt);
    end
    run_op(32'd100, 32'd7, q, r, dbz, lat, ok, fn);
    n_cmp++;
    if (!ok || q !== 32'd14 || r !== 32'd2 || dbz !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_next: got ok=%b q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0", ok, q,
               r, dbz);
    end
  endtask

  task automatic test_back_to_back;
    logic [LEN-1:0] qa, ra, qb, rb, eqa, era, eqb, erb;
    logic [LEN-1:0] a1, b1, a2, b2;
    int n_fin;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom;
    ref_div(a1, b1, eqa, era);
    ref_div(a2, b2, eqb, erb);
    qa = '0; ra = '0; qb = '0; rb = '0;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = a1;
    bus.divisor  = b1;
    @(posedge clk); #1;
    bus.dividend = a2;
    bus.divisor  = b2;
    n_fin = 0;
    for (int i = 0; i < 200 && n_fin < 2; i++) begin
      @(posedge clk); #1;
      if (bus.finish) begin
        n_fin++;
        if (n_fin == 1) begin
          qa = bus.quotient; ra = bus.remainder;
        end else begin
          qb = bus.quotient; rb = bus.remainder;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    n_cmp++;
    if (n_fin != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d finishes want 2", n_fin);
    end
    n_cmp++;
    if (qa !== eqa || ra !== era) begin
      n_err++; $display("FAIL b2b_first: got q=%h r=%h want q=%h r=%h", qa, ra, eqa, era);
    end
    n_cmp++;
    if (qb !== eqb || rb !== erb) begin
      n_err++; $display("FAIL b2b_second: got q=%h r=%h want q=%h r=%h", qb, rb, eqb, erb);
    end
  endtask

  task automatic test_random;
    logic [LEN-1:0] a, b, q, r, eq, er;
    logic dbz, fn;
    logic [2*LEN-1:0] recon;
    int lat;
    bit ok;
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 5)
        1: b = 32'd1;
        2: b = a;
        3: begin a[LEN-1] = 1'b1; b[LEN-1] = 1'b1; end
        4: b = $urandom_range(1, 255);
        default: ;
      endcase
      if (b == 0) b = 32'd1;
      run_op(a, b, q, r, dbz, lat, ok, fn);
      ref_div(a, b, eq, er);
      n_cmp++;
      if (!ok || lat != LEN + 1 || fn !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_timing: got ok=%b lat=%0d next_fin=%b want lat=%0d", i, ok, lat,
                 fn, LEN + 1);
      end
      n_cmp++;
      if (q !== eq || r !== er || dbz !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_result: %h/%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=0", i, a,
                 b, q, r, dbz, eq, er);
      end
      recon = q * b + r;
      n_cmp++;
      if (recon !== {32'd0, a} || r >= b) begin
        n_err++;
        $display("FAIL rand%0d_invariant: got q*b+r=%h r=%h want %h with r<%h", i, recon, r, a,
                 b);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
